// File: rtl/tdm_demux1_2.sv
// tdm_demux1_2: splits an interleaved slot0/slot1 word stream into two channels,
// presenting each completed pair on out1/out2 with a one-cycle out_valid strobe.
module tdm_demux1_2 #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enb,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             sync,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic             out_valid,
    output logic             frame_err,
    output logic             locked,
    output logic [CNT_W-1:0] frame_cnt
);
    localparam logic [1:0] HUNT  = 2'd0;
    localparam logic [1:0] SLOT0 = 2'd1;
    localparam logic [1:0] SLOT1 = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_hold;
    logic [WIDTH-1:0] r_out1;
    logic [WIDTH-1:0] r_out2;
    logic             r_out_valid;
    logic             r_frame_err;
    logic [CNT_W-1:0] r_frame_cnt;

    logic             w_acc;
    logic             w_pair;
    logic             w_err;
    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] w_hold_nxt;

    // Any sync=1 word restarts a pair; a sync=0 word only completes one from SLOT1.
    always_comb begin
        w_acc       = enb & din_valid;
        w_pair      = w_acc & ~sync & (r_state == SLOT1);
        w_err       = w_acc & (sync ? (r_state == SLOT1) : (r_state == SLOT0));
        w_state_nxt = !enb ? HUNT : !din_valid ? r_state : sync ? SLOT1 :
                      (r_state == SLOT1) ? SLOT0 : HUNT;
        w_hold_nxt  = !enb ? '0 : (w_acc & sync) ? din : r_hold;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= HUNT;
            r_hold      <= '0;
            r_out1      <= '0;
            r_out2      <= '0;
            r_out_valid <= 1'b0;
            r_frame_err <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_hold      <= w_hold_nxt;
            r_out_valid <= w_pair;
            r_frame_err <= w_err;
            if (w_pair) begin
                r_out1      <= r_hold;
                r_out2      <= din;
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    assign out1      = r_out1;
    assign out2      = r_out2;
    assign out_valid = r_out_valid;
    assign frame_err = r_frame_err;
    assign locked    = (r_state != HUNT);
    assign frame_cnt = r_frame_cnt;
endmodule

// File: tb/tb_tdm_demux1_2.sv
// tb_tdm_demux1_2: directed-vector bench for the 1:2 TDM receive demux.
module tb_tdm_demux1_2;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enb = 1'b0;
    logic [7:0] din = '0;
    logic       din_valid = 1'b0;
    logic       sync = 1'b0;
    logic [7:0] out1;
    logic [7:0] out2;
    logic       out_valid;
    logic       frame_err;
    logic       locked;
    logic [7:0] frame_cnt;
    int         n_checks = 0;
    int         n_fails = 0;

    tdm_demux1_2 #(.WIDTH(8), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .enb(enb), .din(din), .din_valid(din_valid),
        .sync(sync), .out1(out1), .out2(out2), .out_valid(out_valid),
        .frame_err(frame_err), .locked(locked), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle starting at a negedge; returns at the next negedge.
    task automatic step(input logic e, input logic v, input logic [7:0] d, input logic s);
        enb = e;
        din_valid = v;
        din = d;
        sync = s;
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_out1", out1, 0);
        chk("rst_out2", out2, 0);
        chk("rst_ov", out_valid, 0);
        chk("rst_err", frame_err, 0);
        chk("rst_lock", locked, 0);
        chk("rst_cnt", frame_cnt, 0);
        reset = 1'b0;
        @(negedge clk);
        // basic pair
        step(1, 1, 8'hA5, 1);
        chk("b_lock0", locked, 1);
        chk("b_ov0", out_valid, 0);
        step(1, 1, 8'h3C, 0);
        chk("b_out1", out1, 8'hA5);
        chk("b_out2", out2, 8'h3C);
        chk("b_ov", out_valid, 1);
        chk("b_cnt", frame_cnt, 1);
        chk("b_lock", locked, 1);
        step(1, 0, 8'h00, 0);
        chk("b_ov_pulse", out_valid, 0);
        // gaps between slots
        step(1, 1, 8'h11, 1);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 8'hFF, 0);
            chk("g_idle_ov", out_valid, 0);
        end
        step(1, 1, 8'h22, 0);
        chk("g_out1", out1, 8'h11);
        chk("g_out2", out2, 8'h22);
        chk("g_ov", out_valid, 1);
        chk("g_cnt", frame_cnt, 2);
        step(1, 0, 8'h00, 0);
        chk("g_ov_pulse", out_valid, 0);
        // framing errors
        step(1, 1, 8'h33, 1);
        step(1, 1, 8'h44, 1);
        chk("f_err1", frame_err, 1);
        chk("f_ov1", out_valid, 0);
        chk("f_lock1", locked, 1);
        step(1, 1, 8'h55, 0);
        chk("f_out1", out1, 8'h44);
        chk("f_out2", out2, 8'h55);
        chk("f_ov2", out_valid, 1);
        chk("f_err2", frame_err, 0);
        chk("f_cnt", frame_cnt, 3);
        step(1, 1, 8'h66, 0);
        chk("f_err3", frame_err, 1);
        chk("f_lock3", locked, 0);
        chk("f_ov3", out_valid, 0);
        step(1, 1, 8'h67, 0);
        chk("f_hunt_err", frame_err, 0);
        chk("f_hunt_lock", locked, 0);
        chk("f_hunt_out1", out1, 8'h44);
        // enable drop
        step(1, 1, 8'h77, 1);
        chk("e_lock0", locked, 1);
        step(0, 1, 8'h88, 0);
        chk("e_lock1", locked, 0);
        chk("e_ov1", out_valid, 0);
        step(1, 1, 8'h88, 0);
        chk("e_ov2", out_valid, 0);
        chk("e_out1", out1, 8'h44);
        chk("e_out2", out2, 8'h55);
        chk("e_lock2", locked, 0);
        chk("e_err2", frame_err, 0);
        step(1, 1, 8'h99, 1);
        step(1, 1, 8'hAA, 0);
        chk("e_res_out1", out1, 8'h99);
        chk("e_res_out2", out2, 8'hAA);
        chk("e_res_cnt", frame_cnt, 4);
        // async reset with a pending slot0 word
        step(1, 1, 8'hBB, 1);
        chk("r_lock_pre", locked, 1);
        enb = 1'b0;
        din_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("r_out1", out1, 0);
        chk("r_out2", out2, 0);
        chk("r_cnt", frame_cnt, 0);
        chk("r_lock", locked, 0);
        chk("r_ov", out_valid, 0);
        @(negedge clk);
        reset = 1'b0;
        step(1, 1, 8'hCC, 0);
        chk("r_pending_ov", out_valid, 0);
        chk("r_pending_lock", locked, 0);
        // counter wrap
        for (int i = 0; i < 255; i++) begin
            step(1, 1, i[7:0], 1);
            step(1, 1, ~i[7:0], 0);
        end
        chk("w_cnt255", frame_cnt, 255);
        chk("w_out1_254", out1, 8'd254);
        step(1, 1, 8'h5A, 1);
        step(1, 1, 8'hA5, 0);
        chk("w_cnt0", frame_cnt, 0);
        chk("w_ov", out_valid, 1);
        chk("w_out1", out1, 8'h5A);
        chk("w_out2", out2, 8'hA5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
